// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants for the hazard sequencer and its consumers
package cpu_pkg;
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;
  localparam logic [1:0] ST_REDIR   = 2'd3;
  localparam logic [31:0] NOP_INSN  = 32'h00000013;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status in, stall/flush controls and debug statistics out
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_Ra;
  logic [4:0]       id_Rb;
  logic             id_use_Ra;
  logic             id_use_Rb;
  logic [4:0]       ex_Rd;
  logic             ex_RegWr;
  logic             ex_MemtoReg;
  logic             mem_Branch;
  logic             mem_Zero;
  logic             mem_Jump;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pipe_freeze;
  logic             pc_redirect;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;
  modport master (
    output id_Ra, id_Rb, id_use_Ra, id_use_Rb, ex_Rd, ex_RegWr, ex_MemtoReg,
           mem_Branch, mem_Zero, mem_Jump, mem_req, mem_ready,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           pipe_freeze, pc_redirect, state, stall_cnt, flush_cnt, mem_timeout
  );
  modport slave (
    input  id_Ra, id_Rb, id_use_Ra, id_use_Rb, ex_Rd, ex_RegWr, ex_MemtoReg,
           mem_Branch, mem_Zero, mem_Jump, mem_req, mem_ready,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           pipe_freeze, pc_redirect, state, stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  // count up on inc until every bit is set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, MEM-resolved redirect and memory-wait freeze sequencer
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input logic                   CLK,
  input logic                   Resetn,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [1:0]    st;
  logic [1:0]    nxt;
  logic          pend;
  logic [WW-1:0] wait_cnt;
  logic          timeout;
  logic          mem_wait;
  logic          take;
  logic          load_use;
  logic          redirect;
  logic          lu_stall;
  logic          stall;
  // hazard classification; a redirect owed from a frozen cycle fires as soon as memory lets go
  always_comb begin
    mem_wait = bus.mem_req & ~bus.mem_ready;
    take     = bus.mem_Jump | (bus.mem_Branch & bus.mem_Zero);
    load_use = bus.ex_MemtoReg & bus.ex_RegWr & (bus.ex_Rd != 5'd0) &
               ((bus.id_use_Ra & (bus.id_Ra == bus.ex_Rd)) | (bus.id_use_Rb & (bus.id_Rb == bus.ex_Rd)));
    redirect = ~mem_wait & (take | pend);
    lu_stall = ~mem_wait & ~redirect & load_use;
    stall    = mem_wait | lu_stall;
    nxt      = mem_wait ? ST_MEMWAIT : redirect ? ST_REDIR : lu_stall ? ST_LDSTALL : ST_RUN;
  end
  assign bus.pipe_freeze = Resetn & mem_wait;
  assign bus.pc_stall    = Resetn & stall;
  assign bus.ifid_stall  = Resetn & stall;
  assign bus.idex_bubble = Resetn & lu_stall;
  assign bus.pc_redirect = Resetn & redirect;
  assign bus.ifid_flush  = Resetn & redirect;
  assign bus.idex_flush  = Resetn & redirect;
  assign bus.exmem_flush = Resetn & redirect;
  assign bus.state       = st;
  assign bus.mem_timeout = timeout;
  // state, pending redirect, wait length and sticky timeout
  always_ff @(posedge CLK or negedge Resetn)
    if (!Resetn) begin
      st       <= ST_RUN;
      pend     <= 1'b0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      st       <= nxt;
      pend     <= mem_wait & (pend | take);
      wait_cnt <= !mem_wait ? '0 : (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
      timeout  <= timeout | (mem_wait & (wait_cnt == WW'(MAX_WAIT - 1)));
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(CLK), .rst_n(Resetn), .inc(stall), .q(bus.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(CLK), .rst_n(Resetn), .inc(redirect), .q(bus.flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of the hazard sequencer against a cycle model
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W    = 6;
  localparam int MAX_WAIT = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;
  logic CLK = 1'b0;
  logic Resetn;
  int n_vec = 0;
  int n_err = 0;
  int m_state, m_wait, m_stall, m_flush;
  bit m_pend, m_to;
  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (.CLK(CLK), .Resetn(Resetn), .bus(hif));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] ctl();
    return {hif.pipe_freeze, hif.pc_stall, hif.ifid_stall, hif.idex_bubble,
            hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.pc_redirect};
  endfunction
  task automatic clr();
    {hif.id_Ra, hif.id_Rb, hif.ex_Rd} = '0;
    {hif.id_use_Ra, hif.id_use_Rb, hif.ex_RegWr, hif.ex_MemtoReg} = '0;
    {hif.mem_Branch, hif.mem_Zero, hif.mem_Jump, hif.mem_req, hif.mem_ready} = '0;
  endtask
  task automatic cyc();
    bit w, t, lu, red, l;
    #4;
    w   = hif.mem_req && !hif.mem_ready;
    t   = hif.mem_Jump || (hif.mem_Branch && hif.mem_Zero);
    lu  = hif.ex_MemtoReg && hif.ex_RegWr && hif.ex_Rd != 0 &&
          ((hif.id_use_Ra && hif.id_Ra == hif.ex_Rd) || (hif.id_use_Rb && hif.id_Rb == hif.ex_Rd));
    red = !w && (t || m_pend);
    l   = !w && !red && lu;
    chk("ctl", 32'(ctl()), 32'({w, w | l, w | l, l, red, red, red, red}));
    chk("state", 32'(hif.state), m_state);
    chk("stall_cnt", 32'(hif.stall_cnt), m_stall);
    chk("flush_cnt", 32'(hif.flush_cnt), m_flush);
    chk("timeout", 32'(hif.mem_timeout), 32'(m_to));
    @(posedge CLK);
    if (w || l) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
    if (red) m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
    m_state = w ? 2 : red ? 3 : l ? 1 : 0;
    if (w) begin
      m_wait++;
      if (m_wait >= MAX_WAIT) m_to = 1;
      m_pend = m_pend || t;
    end else begin
      m_wait = 0;
      m_pend = 0;
    end
    #1;
  endtask
  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl()), 0);
    chk("rst_state", 32'(hif.state), 0);
    chk("rst_stats", 32'({hif.stall_cnt, hif.flush_cnt, hif.mem_timeout}), 0);
    clr();
    {m_state, m_wait, m_stall, m_flush} = '0;
    {m_pend, m_to} = '0;
    @(posedge CLK);
    #1;
    Resetn = 1'b1;
  endtask
  initial begin
    clr();
    Resetn = 1'b1;
    #2;
    do_reset();
    {hif.ex_MemtoReg, hif.ex_RegWr, hif.id_use_Ra} = 3'b111;
    hif.ex_Rd = 5'd5;
    hif.id_Ra = 5'd5;
    cyc();
    chk("lu_state", 32'(hif.state), 1);
    chk("lu_stall_cnt", 32'(hif.stall_cnt), 1);
    hif.ex_Rd = 5'd0;
    hif.id_Ra = 5'd0;
    cyc();
    chk("lu_rd0_state", 32'(hif.state), 0);
    chk("lu_rd0_cnt", 32'(hif.stall_cnt), 1);
    do_reset();
    {hif.mem_Branch, hif.mem_Zero} = 2'b11;
    cyc();
    chk("br_state", 32'(hif.state), 3);
    chk("br_flush_cnt", 32'(hif.flush_cnt), 1);
    hif.mem_Zero = 1'b0;
    cyc();
    chk("br_nt_cnt", 32'(hif.flush_cnt), 1);
    do_reset();
    hif.mem_req = 1'b1;
    repeat (3) cyc();
    chk("wait_state", 32'(hif.state), 2);
    hif.mem_ready = 1'b1;
    cyc();
    chk("wait_stall_cnt", 32'(hif.stall_cnt), 3);
    chk("wait_timeout", 32'(hif.mem_timeout), 0);
    do_reset();
    {hif.mem_req, hif.mem_Jump} = 2'b11;
    repeat (2) cyc();
    chk("wj_flush_frozen", 32'(hif.flush_cnt), 0);
    {hif.mem_ready, hif.mem_Jump} = 2'b10;
    cyc();
    chk("wj_flush_cnt", 32'(hif.flush_cnt), 1);
    chk("wj_state", 32'(hif.state), 3);
    do_reset();
    hif.mem_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == MAX_WAIT - 1) chk("to_early", 32'(hif.mem_timeout), 0);
      if (i == MAX_WAIT) chk("to_set", 32'(hif.mem_timeout), 1);
    end
    hif.mem_ready = 1'b1;
    cyc();
    hif.mem_req = 1'b0;
    cyc();
    chk("to_sticky", 32'(hif.mem_timeout), 1);
    do_reset();
    {hif.mem_req, hif.mem_Jump} = 2'b11;
    repeat (2) cyc();
    do_reset();
    cyc();
    chk("rw_state", 32'(hif.state), 0);
    chk("rw_no_redirect", 32'(hif.flush_cnt), 0);
    do_reset();
    repeat (800) begin
      hif.ex_Rd       = 5'($urandom_range(0, 3));
      hif.id_Ra       = 5'($urandom_range(0, 3));
      hif.id_Rb       = 5'($urandom_range(0, 3));
      hif.id_use_Ra   = 1'($urandom_range(0, 1));
      hif.id_use_Rb   = 1'($urandom_range(0, 1));
      hif.ex_MemtoReg = 1'($urandom_range(0, 1));
      hif.ex_RegWr    = ($urandom_range(0, 3) != 0);
      hif.mem_Branch  = ($urandom_range(0, 3) == 0);
      hif.mem_Zero    = 1'($urandom_range(0, 1));
      hif.mem_Jump    = ($urandom_range(0, 9) == 0);
      hif.mem_req     = ($urandom_range(0, 2) == 0);
      hif.mem_ready   = ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX.
- Applies control-transfer flushes resolved at the MEM stage.
- Freezes the pipeline while data memory has not acknowledged a request.
- Keeps stall/flush statistics and a sticky memory-timeout flag for the top-level debug outputs.

Parameters:
CNT_W, 16, width of the saturating stall and flush statistic counters
MAX_WAIT, 8, memory wait cycles before mem_timeout is set (≥1)

Ports:
CLK  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
id_Ra  input  5  rs1 index of the instruction in ID
id_Rb  input  5  rs2 index of the instruction in ID
id_use_Ra  input  1  ID instruction reads rs1
id_use_Rb  input  1  ID instruction reads rs2
ex_Rd  input  5  destination of the instruction in EX
ex_RegWr  input  1  EX instruction writes the register file
ex_MemtoReg  input  1  EX instruction is a load
mem_Branch  input  1  MEM-stage instruction is a conditional branch
mem_Zero  input  1  branch condition result latched in EX/MEM
mem_Jump  input  1  MEM-stage instruction is jal/jalr
mem_req  input  1  MEM stage is issuing a data-memory access
mem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold the PC
ifid_stall  output  1  hold the IF/ID register
idex_bubble  output  1  load a NOP into ID/EX
ifid_flush  output  1  clear IF/ID
idex_flush  output  1  clear ID/EX
exmem_flush  output  1  clear EX/MEM
pipe_freeze  output  1  hold all pipeline registers and the PC
pc_redirect  output  1  PC selects the MEM-stage target this cycle
state  output  2  FSM state: 0 RUN, 1 LDSTALL, 2 MEMWAIT, 3 REDIR
stall_cnt  output  CNT_W  saturating count of stall cycles (load-use plus freeze)
flush_cnt  output  CNT_W  saturating count of redirect events
mem_timeout  output  1  sticky flag: a memory wait exceeded MAX_WAIT

Behaviour:
- Reset: asynchronous, taken while Resetn=0.
  - State goes to RUN; counters, wait counter, pending flag and mem_timeout clear.
  - All control outputs are 0 during reset.
- Control outputs: combinational from the current state and inputs.
- Counters, state, pending flag, wait counter and mem_timeout: registered on the CLK rising edge.
- Internal signals:
  - load_use = ex_MemtoReg & ex_RegWr & (ex_Rd≠0) & ((id_use_Ra & id_Ra==ex_Rd) | (id_use_Rb & id_Rb==ex_Rd)).
  - take = mem_Jump | (mem_Branch & mem_Zero).
  - wait = mem_req & ~mem_ready.
- Priority when several conditions hold: wait > take > load_use.
- wait:
  - pipe_freeze=1, pc_stall=1, ifid_stall=1; all flush and redirect outputs are 0.
  - Next state is MEMWAIT.
  - If take is also high, set an internal pending flag so the redirect is not lost.
- take (no wait):
  - pc_redirect=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - Next state is REDIR; flush_cnt increments.
  - load_use is ignored in this cycle because the ID instruction is being discarded.
- load_use only:
  - pc_stall=1, ifid_stall=1, idex_bubble=1.
  - Next state is LDSTALL.
  - The stall lasts exactly one cycle; the next cycle re-evaluates, and normally no hazard remains because EX now holds a bubble.
- MEMWAIT state:
  - The wait counter increments each waiting cycle.
  - If the counter reaches MAX_WAIT, mem_timeout is set and stays 1 until reset. The freeze continues regardless.
  - On the cycle mem_ready=1:
    - The freeze releases and the wait counter clears.
    - If the pending flag is set, or take is high, the redirect is applied that same cycle and the pending flag clears.
- REDIR and LDSTALL states: informational only. Each returns to RUN, or to whichever state the priority rules select, on the next cycle.
- stall_cnt increments on every cycle with pc_stall=1. Both counters saturate at all-ones with no wrap.
- Reset mid-wait or mid-redirect: everything is discarded; no pending redirect survives reset.
- ex_Rd=0 never produces a load-use stall.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding constants ST_RUN, ST_LDSTALL, ST_MEMWAIT, ST_REDIR.
  - The NOP instruction constant 32'h00000013 used by idex_bubble consumers.
- Sub-module sat_counter (parameter W, with inc input), instantiated twice for stall_cnt and flush_cnt.
- Hazard detection, the FSM and the wait counter stay in the top module.

Test Plan:
- Load-use:
  - Stimulus: ex_MemtoReg=1, ex_RegWr=1, ex_Rd=5, id_Ra=5, id_use_Ra=1.
  - Response: one cycle with pc_stall=ifid_stall=idex_bubble=1, state=1, stall_cnt 0→1. With ex_Rd=0 and the same ID inputs, no stall.
- Taken branch:
  - Stimulus: mem_Branch=1, mem_Zero=1.
  - Response: pc_redirect and all three flushes high for 1 cycle, state=3, flush_cnt=1. With mem_Zero=0, no flush.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Response: pipe_freeze high for exactly 3 cycles, stall_cnt=3, mem_timeout stays 0.
- Simultaneous wait + jump:
  - Stimulus: mem_Jump=1 during a 2-cycle wait.
  - Response: no redirect while frozen; pc_redirect=1 on the mem_ready cycle; flush_cnt=1.
- Timeout with MAX_WAIT=8:
  - Stimulus: hold wait for 10 cycles.
  - Response: mem_timeout=1 from the 8th wait cycle and stays 1 after release, until Resetn=0.
- Reset mid-wait:
  - Stimulus: deassert Resetn during MEMWAIT with the pending flag set.
  - Response: all outputs 0 immediately; after release state=0 and no redirect issues.
